// File: rtl/pipelined_cra_pkg.sv
// rtl/pipelined_cra_pkg.sv - shared defaults, segment geometry helpers and the full-adder cell
package pipelined_cra_pkg;

  localparam int WIDTH_DEF = 18;
  localparam int SEG_DEF   = 6;

  function automatic int nstage(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  function automatic int seg_lo(input int k, input int seg);
    return k * seg;
  endfunction

  // The last segment takes whatever bits remain above the full segments.
  function automatic int seg_w(input int k, input int width, input int seg);
    int rem;
    rem = width - k * seg;
    return (rem < seg) ? rem : seg;
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/pipelined_cra_if.sv
// rtl/pipelined_cra_if.sv - operand/result handshake bundle for pipelined_cra
// PIPELINED_CRA_OVF_EN adds the registered signed-overflow flag ovf.
interface pipelined_cra_if import pipelined_cra_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Co;
`ifdef PIPELINED_CRA_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, X, Y, Ci, sub, out_ready,
    input  in_ready, out_valid, S, Co, ovf
  );
  modport slave (
    input  in_valid, X, Y, Ci, sub, out_ready,
    output in_ready, out_valid, S, Co, ovf
  );
`else
  modport master (
    output in_valid, X, Y, Ci, sub, out_ready,
    input  in_ready, out_valid, S, Co
  );
  modport slave (
    input  in_valid, X, Y, Ci, sub, out_ready,
    output in_ready, out_valid, S, Co
  );
`endif
endinterface

// File: rtl/cra_segment.sv
// rtl/cra_segment.sv - combinational W-bit ripple chain of full-adder cells
module cra_segment import pipelined_cra_pkg::*; #(
  parameter int W = SEG_DEF
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] Sum,
  output logic         Cout
);

  always_comb begin
    logic cc;
    Sum = '0;
    cc  = Cin;
    for (int i = 0; i < W; i++) begin
      {cc, Sum[i]} = fa(A[i], B[i], cc);
    end
    Cout = cc;
  end

endmodule

// File: rtl/pipelined_cra.sv
// rtl/pipelined_cra.sv - segmented, pipelined ripple-carry add/subtract with valid/ready
// PIPELINED_CRA_OVF_EN adds the registered signed-overflow output ovf.
module pipelined_cra import pipelined_cra_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  pipelined_cra_if.slave bus
);

  localparam int NSTAGE = nstage(WIDTH, SEG);

  logic             en;
  logic [WIDTH-1:0] y_cond;
  logic             carry0;

  assign y_cond      = bus.sub ? ~bus.Y : bus.Y;
  assign carry0      = bus.sub | bus.Ci;
  assign en          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = en;

  // Stage k adds its segment and registers it. mix_r holds finished sum bits below
  // the segment top and still-unconsumed X bits above; y_r carries the unconsumed Y' bits.
  for (genvar k = 0; k < NSTAGE; k++) begin : stg
    localparam int LO = seg_lo(k, SEG);
    localparam int W  = seg_w(k, WIDTH, SEG);
    localparam int HI = LO + W;

    logic [WIDTH-1:0] mix_in;
    logic [WIDTH-1:0] mix_nx;
    logic [WIDTH-1:0] mix_r;
    logic [WIDTH-1:LO] y_in;
    logic             c_in;
    logic             v_in;
    logic             c_r;
    logic             v_r;
    logic [W-1:0]     sum;
    logic             cout;

    if (k == 0) begin : src
      assign mix_in = bus.X;
      assign y_in   = y_cond;
      assign c_in   = carry0;
      assign v_in   = bus.in_valid;
    end else begin : src
      assign mix_in = stg[k-1].mix_r;
      assign y_in   = stg[k-1].yh.y_r;
      assign c_in   = stg[k-1].c_r;
      assign v_in   = stg[k-1].v_r;
    end

    cra_segment #(.W(W)) u_seg (
      .A    (mix_in[HI-1:LO]),
      .B    (y_in[HI-1:LO]),
      .Cin  (c_in),
      .Sum  (sum),
      .Cout (cout)
    );

    always_comb begin
      mix_nx         = mix_in;
      mix_nx[HI-1:LO] = sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        mix_r <= '0;
      end else if (en) begin
        v_r   <= v_in;
        c_r   <= cout;
        mix_r <= mix_nx;
      end
    end

    if (k < NSTAGE - 1) begin : yh
      logic [WIDTH-1:HI] y_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_r <= '0;
        end else if (en) begin
          y_r <= y_in[WIDTH-1:HI];
        end
      end
    end

`ifdef PIPELINED_CRA_OVF_EN
    if (k == NSTAGE - 1) begin : ov
      logic ovf_r;
      // Carry into the MSB is recovered from the MSB sum and operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (en) begin
          ovf_r <= cout ^ (mix_in[WIDTH-1] ^ y_in[WIDTH-1] ^ sum[W-1]);
        end
      end
    end
`endif
  end

  assign bus.out_valid = stg[NSTAGE-1].v_r;
  assign bus.S         = stg[NSTAGE-1].mix_r;
  assign bus.Co        = stg[NSTAGE-1].c_r;
`ifdef PIPELINED_CRA_OVF_EN
  assign bus.ovf       = stg[NSTAGE-1].ov.ovf_r;
`endif

endmodule

// File: doc/pipelined_cra.md
Name: pipelined_cra

Overview:
Parametrised, pipelined successor to the 18-bit ripple-carry adder used in the radix-4 multiplier datapath. The carry chain is split into SEG-bit segments with a register between segments; operands and partial sums are skewed and deskewed internally. Supports add/subtract per transaction and a valid/ready handshake, so it can sit between the partial-product reducer and the product register at higher clock rates.

Parameters:
WIDTH, 18, operand/sum width in bits (>=2)
SEG, 6, bits per pipeline segment (1..WIDTH); NSTAGE = ceil(WIDTH/SEG); last segment holds the remainder bits

Ports:
clk  in  1  clock, all state rises on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands presented
in_ready  out  1  block accepts operands this cycle
X  in  WIDTH  signed operand A
Y  in  WIDTH  signed operand B
Ci  in  1  carry-in (add mode only)
sub  in  1  1: S = X - Y; 0: S = X + Y + Ci
out_valid  out  1  S/Co valid
out_ready  in  1  downstream accepts result
S  out  WIDTH  signed sum/difference
Co  out  1  raw carry out of the MSB

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, all data/skew registers 0; out_valid=0, S=0, Co=0; in_ready=1 after reset is released. Reset mid-operation discards every in-flight transaction; no partial result is ever presented.
- Global advance enable: en = out_ready | ~out_valid. in_ready = en. A transfer in = in_valid & in_ready; a transfer out = out_valid & out_ready.
- When en=1, every stage register loads from its predecessor; stage 0 loads {X, Y', carry} with valid = in_valid. When en=0, all stages hold. Bubbles travel down the pipe; they are not collapsed.
- Operand conditioning at the input: Y' = sub ? ~Y : Y; carry0 = sub ? 1 : Ci (Ci is ignored when sub=1).
- Stage k (0..NSTAGE-1) adds bits [k*SEG +: SEG] (the last stage uses the remaining bits) of X and Y' with the carry registered from stage k-1, using plain ripple logic. Its sum bits and carry-out are registered. Upper operand bits not yet consumed travel in skew registers; lower sum bits travel in deskew registers.
- Latency: exactly NSTAGE accepted-to-valid cycles with out_ready held high (WIDTH=18, SEG=6 gives 3). Throughput: 1 per cycle.
- S = full WIDTH bits modulo 2^WIDTH (two's complement wrap). Co = carry out of bit WIDTH-1. No saturation.
- With out_valid=1 and out_ready=0, S/Co/out_valid hold stable and in_ready=0.
- Corner cases:
  - SEG >= WIDTH degenerates to NSTAGE=1: a single registered ripple adder with 1-cycle latency.
  - SEG=1 gives NSTAGE=WIDTH.
  - A simultaneous in-transfer and out-transfer is legal every cycle.

Optional Feature:
Macro PIPELINED_CRA_OVF_EN.
- Defined: an extra output port ovf (1 bit). It is the signed overflow of the final stage, computed as carry into MSB XOR carry out of MSB, and is registered with S. It resets to 0 and follows the same hold/valid rules as S.
- Undefined: the ovf port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package pipelined_cra_pkg:
  - function nstage(WIDTH, SEG) returning the ceiling division
  - function seg_lo(k, SEG) and seg_w(k, WIDTH, SEG) giving the segment bit offset and width
  - localparam defaults WIDTH_DEF=18, SEG_DEF=6
- Sub-module cra_segment, parametrised by segment width W: combinational W-bit ripple chain of the existing FA cell with ports A, B, Cin, Sum, Cout. It is instantiated NSTAGE times via generate. Registers stay in pipelined_cra.

Test Plan:
- WIDTH=18, SEG=6, out_ready=1: X=3, Y=7, Ci=0, sub=0 -> after 3 cycles out_valid=1, S=10, Co=0.
- Carry across every segment boundary: X=18'h3FFFF, Y=1, Ci=0 -> S=0, Co=1. Then X=18'h0003F, Y=1 -> S=18'h00040, Co=0.
- Subtract with Ci ignored: X=5, Y=9, sub=1, Ci=1 -> S=18'h3FFFC (-4), Co=0. With PIPELINED_CRA_OVF_EN: X=18'h1FFFF, Y=1, sub=0 -> ovf=1, S=18'h20000.
- Back-to-back with stall: stream 6 random vectors with in_valid=1, hold out_ready=0 for 4 cycles mid-stream -> in_ready drops, no result is lost or duplicated, and results emerge in order matching a reference model.
- Reset mid-operation: accept 2 vectors, assert rst_n=0 for 1 cycle -> out_valid=0, S=0, Co=0 immediately; no stale result appears after release.
- Parameter sweep: (WIDTH,SEG) = (18,18), (18,1), (24,5), (8,3) -> latency equals NSTAGE and 200 random vectors match X±Y(+Ci) modulo 2^WIDTH.
